// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - multi-channel button synchroniser, debouncer, press/release/long-press/repeat pulses
module debounce_multi #(
   parameter int NUM_BUTTONS       = 4,
   parameter int DEBOUNCE_CYCLES   = 20_000,
   parameter int LONG_PRESS_CYCLES = 5_000_000,
   parameter int REPEAT_CYCLES     = 1_000_000,
   parameter int ACTIVE_LOW        = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_BUTTONS-1:0] button_in,
   output logic [NUM_BUTTONS-1:0] button_state,
   output logic [NUM_BUTTONS-1:0] pressed_pulse,
   output logic [NUM_BUTTONS-1:0] released_pulse,
   output logic [NUM_BUTTONS-1:0] long_press_pulse,
   output logic [NUM_BUTTONS-1:0] repeat_pulse
);

   // Raw level of a released button, used as the synchroniser reset value
   localparam logic REL_LVL = (ACTIVE_LOW != 0);

   localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int LONG_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
   localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam int HOLD_W = (LONG_W > REP_W) ? LONG_W : REP_W;

   localparam logic [DEB_W-1:0]  DEB_TERM  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] LONG_TERM = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [HOLD_W-1:0] REP_TERM  = (REPEAT_CYCLES > 0) ? HOLD_W'(REPEAT_CYCLES - 1) : '0;
   localparam logic              REP_EN    = (REPEAT_CYCLES > 0);

   logic [NUM_BUTTONS-1:0] sync_0;
   logic [NUM_BUTTONS-1:0] sync_1;

   // Two-flop synchroniser for every raw button line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_0 <= {NUM_BUTTONS{REL_LVL}};
         sync_1 <= {NUM_BUTTONS{REL_LVL}};
      end else begin
         sync_0 <= button_in;
         sync_1 <= sync_0;
      end
   end

   genvar i;
   for (i = 0; i < NUM_BUTTONS; i++) begin : g_ch
      typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_LONG, ST_REPEAT} state_t;

      state_t            state;
      state_t            state_nxt;
      logic [DEB_W-1:0]  deb_cnt;
      logic [HOLD_W-1:0] hold_cnt;
      logic [HOLD_W-1:0] hold_cnt_nxt;
      logic              level;
      logic              stable;
      logic              stable_d;
      logic              press_q;
      logic              rel_q;
      logic              long_fire;
      logic              rep_fire;
      logic              long_q;
      logic              rep_q;

      // Polarity-normalised synchronised level: 1 means pressed
      assign level = (ACTIVE_LOW != 0) ? ~sync_1[i] : sync_1[i];

      // Debounce filter: accept a new level only after an unbroken run of disagreeing cycles
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            deb_cnt <= '0;
            stable  <= 1'b0;
         end else if (level == stable) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_TERM) begin
            stable  <= level;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end

      // Edge detection on the debounced level gives registered press/release pulses
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stable_d <= 1'b0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
         end else begin
            stable_d <= stable;
            press_q  <= stable & ~stable_d;
            rel_q    <= ~stable & stable_d;
         end
      end

      // Hold FSM state, hold counter and registered long/repeat pulses
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            long_q   <= 1'b0;
            rep_q    <= 1'b0;
         end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            long_q   <= long_fire;
            rep_q    <= rep_fire;
         end
      end

      // Hold FSM next state: release always returns to IDLE and clears the counter
      always_comb begin
         state_nxt    = state;
         hold_cnt_nxt = hold_cnt;
         if (!stable) begin
            state_nxt    = ST_IDLE;
            hold_cnt_nxt = '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state_nxt    = ST_HOLD;
                  hold_cnt_nxt = '0;
               end
               ST_HOLD: begin
                  if (hold_cnt == LONG_TERM) begin
                     state_nxt    = ST_LONG;
                     hold_cnt_nxt = '0;
                  end else begin
                     hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                  end
               end
               ST_LONG, ST_REPEAT: begin
                  if (!REP_EN) begin
                     hold_cnt_nxt = '0;
                  end else if (hold_cnt == REP_TERM) begin
                     state_nxt    = ST_REPEAT;
                     hold_cnt_nxt = '0;
                  end else begin
                     hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                  end
               end
               default: begin
                  state_nxt    = ST_IDLE;
                  hold_cnt_nxt = '0;
               end
            endcase
         end
      end

      // Hold FSM outputs: terminal counts while still pressed fire the long/repeat pulses
      always_comb begin
         long_fire = 1'b0;
         rep_fire  = 1'b0;
         if (stable) begin
            if (state == ST_HOLD && hold_cnt == LONG_TERM) begin
               long_fire = 1'b1;
            end
            if (REP_EN && (state == ST_LONG || state == ST_REPEAT) && hold_cnt == REP_TERM) begin
               rep_fire = 1'b1;
            end
         end
      end

      assign button_state[i]     = stable;
      assign pressed_pulse[i]    = press_q;
      assign released_pulse[i]   = rel_q;
      assign long_press_pulse[i] = long_q;
      assign repeat_pulse[i]     = rep_q;
   end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - self-checking bench for debounce_multi against a timing-rule reference model
module tb_debounce_multi;
   localparam int N  = 2;
   localparam int D  = 4;
   localparam int L  = 10;
   localparam int R  = 5;
   localparam int AL = 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] button_in;
   logic [N-1:0] button_state;
   logic [N-1:0] pressed_pulse;
   logic [N-1:0] released_pulse;
   logic [N-1:0] long_press_pulse;
   logic [N-1:0] repeat_pulse;

   debounce_multi #(
      .NUM_BUTTONS      (N),
      .DEBOUNCE_CYCLES  (D),
      .LONG_PRESS_CYCLES(L),
      .REPEAT_CYCLES    (R),
      .ACTIVE_LOW       (AL)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .button_in       (button_in),
      .button_state    (button_state),
      .pressed_pulse   (pressed_pulse),
      .released_pulse  (released_pulse),
      .long_press_pulse(long_press_pulse),
      .repeat_pulse    (repeat_pulse)
   );

   // 10 time-unit clock
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: raw-sample delay line, disagreement run length, press timestamp
   logic [N-1:0] m_s0, m_s1, m_stable, m_stprev;
   logic [N-1:0] e_press, e_rel, e_long, e_rep;
   int           m_run[N];
   int           m_press_edge[N];
   int           m_edge = 0;
   int           c_press[N], c_rel[N], c_long[N], c_rep[N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s0     = (AL != 0) ? '1 : '0;
      m_s1     = (AL != 0) ? '1 : '0;
      m_stable = '0;
      m_stprev = '0;
      e_press  = '0;
      e_rel    = '0;
      e_long   = '0;
      e_rep    = '0;
      for (int c = 0; c < N; c++) begin
         m_run[c]        = 0;
         m_press_edge[c] = -1;
      end
   endtask

   task automatic clear_counts();
      for (int c = 0; c < N; c++) begin
         c_press[c] = 0;
         c_rel[c]   = 0;
         c_long[c]  = 0;
         c_rep[c]   = 0;
      end
   endtask

   // Advance the model by one clock edge using the inputs the DUT just sampled
   task automatic model_step();
      logic [N-1:0] old_s1;
      logic [N-1:0] old_stable;
      logic         lvl;
      int           t;
      old_s1     = m_s1;
      old_stable = m_stable;
      m_s1       = m_s0;
      m_s0       = button_in;
      m_edge++;
      for (int c = 0; c < N; c++) begin
         lvl = (AL != 0) ? ~old_s1[c] : old_s1[c];
         if (lvl == m_stable[c]) begin
            m_run[c] = 0;
         end else begin
            m_run[c]++;
            if (m_run[c] == D) begin
               m_stable[c] = lvl;
               m_run[c]    = 0;
            end
         end
         e_press[c] = old_stable[c] & ~m_stprev[c];
         e_rel[c]   = ~old_stable[c] & m_stprev[c];
         e_long[c]  = 1'b0;
         e_rep[c]   = 1'b0;
         if (e_press[c]) m_press_edge[c] = m_edge;
         if (!old_stable[c]) begin
            m_press_edge[c] = -1;
         end else if (m_press_edge[c] >= 0) begin
            t = m_edge - m_press_edge[c];
            e_long[c] = (t == L);
            e_rep[c]  = (R > 0) && (t > L) && (((t - L) % R) == 0);
         end
      end
      m_stprev = old_stable;
   endtask

   // One clock: model steps at the edge, DUT outputs checked at the following falling edge
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("button_state", button_state, m_stable);
      chk("pressed_pulse", pressed_pulse, e_press);
      chk("released_pulse", released_pulse, e_rel);
      chk("long_press_pulse", long_press_pulse, e_long);
      chk("repeat_pulse", repeat_pulse, e_rep);
      for (int c = 0; c < N; c++) begin
         c_press[c] += int'(pressed_pulse[c]);
         c_rel[c]   += int'(released_pulse[c]);
         c_long[c]  += int'(long_press_pulse[c]);
         c_rep[c]   += int'(repeat_pulse[c]);
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Asynchronous reset in the middle of the low clock phase
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_button_state", button_state, 0);
      chk("rst_pressed", pressed_pulse, 0);
      chk("rst_released", released_pulse, 0);
      chk("rst_long", long_press_pulse, 0);
      chk("rst_repeat", repeat_pulse, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      button_in = '1;
      rst_n     = 1'b0;
      model_reset();
      clear_counts();
      repeat (2) @(negedge clk);
      chk("init_button_state", button_state, 0);
      chk("init_pressed", pressed_pulse, 0);
      chk("init_released", released_pulse, 0);
      chk("init_long", long_press_pulse, 0);
      chk("init_repeat", repeat_pulse, 0);
      rst_n = 1'b1;
      run(5);

      // Basic press latency on ch0, released just short of long press
      button_in[0] = 1'b0;
      clear_counts();
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (k == 4) chk("t1_state_before", button_state[0], 1'b0);
         if (k == 5) chk("t1_state_after", button_state[0], 1'b1);
         if (k == 5) chk("t1_pulse_early", pressed_pulse[0], 1'b0);
         if (k == 6) chk("t1_pulse", pressed_pulse[0], 1'b1);
         if (k == 7) chk("t1_pulse_end", pressed_pulse[0], 1'b0);
      end
      button_in[0] = 1'b1;
      run(12);
      chk("t1_press_count", c_press[0], 1);
      chk("t1_rel_count", c_rel[0], 1);
      chk("t1_long_count", c_long[0], 0);

      // Bounce shorter than the filter, then a glitch restarting the count
      clear_counts();
      button_in[0] = 1'b0;
      run(3);
      button_in[0] = 1'b1;
      run(10);
      chk("t2_bounce_press", c_press[0], 0);
      chk("t2_bounce_state", button_state[0], 1'b0);
      button_in[0] = 1'b0;
      run(3);
      button_in[0] = 1'b1;
      run(1);
      button_in[0] = 1'b0;
      run(12);
      chk("t2_glitch_press", c_press[0], 1);
      chk("t2_glitch_state", button_state[0], 1'b1);
      button_in[0] = 1'b1;
      run(12);

      // Long hold on ch1 with auto-repeat; release coincides with a would-be repeat
      clear_counts();
      button_in[1] = 1'b0;
      run(40);
      button_in[1] = 1'b1;
      run(15);
      chk("t3_press", c_press[1], 1);
      chk("t3_long", c_long[1], 1);
      chk("t3_repeat", c_rep[1], 5);
      chk("t3_release", c_rel[1], 1);

      // Short press on ch0
      clear_counts();
      button_in[0] = 1'b0;
      run(6);
      button_in[0] = 1'b1;
      run(15);
      chk("t4_press", c_press[0], 1);
      chk("t4_release", c_rel[0], 1);
      chk("t4_long", c_long[0], 0);

      // Both channels together
      button_in = 2'b00;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (k == 6) chk("t5_both", pressed_pulse, 2'b11);
      end
      button_in = 2'b11;
      run(15);

      // Reset while ch0 repeats, button kept low through reset release
      button_in[0] = 1'b0;
      run(30);
      do_reset();
      clear_counts();
      run(30);
      chk("t6_press", c_press[0], 1);
      chk("t6_long", c_long[0], 1);
      chk("t6_repeat", c_rep[0], 2);
      chk("t6_no_release", c_rel[0], 0);
      button_in[0] = 1'b1;
      run(15);

      // Random toggling with occasional long holds, one mid-run reset
      for (int k = 0; k < 1500; k++) begin
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 11) == 0) button_in[c] = ~button_in[c];
         end
         if (k == 700) do_reset();
         cycle();
      end
      button_in = '1;
      run(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
